// File: rtl/mgt_01_fp_round_unit.sv
// ---------------------------------------------------------------------------
// mgt_01_fp_round_unit
//
// Two-stage IEEE-754 binary32 rounding stage between the FU result bus and
// writeback. Stage 1 captures the raw FU result together with the increment
// and inexact decisions. Stage 2 applies the increment, handles carry into
// the exponent, overflow saturation and exception overrides, and registers
// the final result and fflags. A valid/ready handshake is used on both sides.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous active-high reset
//   clk_en_i       0 freezes every register and forces ready_o low
//   valid_i        upstream result present
//   ready_o        input accepted this cycle when valid_i is also high
//   to_round_i     unrounded float {sign, exponent[7:0], mantissa[22:0]}
//   guard_i        guard bit below the mantissa LSB
//   round_i        round bit
//   sticky_i       sticky bit
//   rm_i           RISC-V rounding mode (000 RNE .. 100 RMM, others illegal)
//   overflow_i     FU overflow flag
//   underflow_i    FU underflow flag
//   invalid_op_i   FU invalid-operation flag
//   zero_divide_i  FU divide-by-zero flag
//   valid_o        rounded result present
//   ready_i        downstream accepts the result
//   result_o       rounded float
//   fflags_o       {NV, DZ, OF, UF, NX}
// ---------------------------------------------------------------------------
module mgt_01_fp_round_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] to_round_i,
    input  logic        guard_i,
    input  logic        round_i,
    input  logic        sticky_i,
    input  logic [2:0]  rm_i,
    input  logic        overflow_i,
    input  logic        underflow_i,
    input  logic        invalid_op_i,
    input  logic        zero_divide_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic [4:0]  fflags_o
);

    localparam logic [2:0]  RM_RNE = 3'b000;
    localparam logic [2:0]  RM_RTZ = 3'b001;
    localparam logic [2:0]  RM_RDN = 3'b010;
    localparam logic [2:0]  RM_RUP = 3'b011;
    localparam logic [2:0]  RM_RMM = 3'b100;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG   = 31'h7F80_0000;
    localparam logic [30:0] MAX_MAG   = 31'h7F7F_FFFF;

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv  = ~s2_valid | ready_i;
    assign s1_adv  = ~s1_valid | s2_adv;
    // rst_i is folded in so ready_o is low for the whole reset interval.
    assign ready_o = clk_en_i & ~rst_i & s1_adv;
    assign valid_o = s2_valid;

    // ---------------------------------------------------------------
    // Stage 1 decisions: increment and inexact from the raw inputs
    // ---------------------------------------------------------------
    logic in_inexact;
    logic in_inc;
    logic in_rm_illegal;

    // NOTE: every output of an always_comb gets a default before the case,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        in_inexact    = guard_i | round_i | sticky_i;
        in_inc        = 1'b0;
        in_rm_illegal = 1'b0;
        case (rm_i)
            RM_RNE:  in_inc = guard_i & (round_i | sticky_i | to_round_i[0]);
            RM_RTZ:  in_inc = 1'b0;
            RM_RDN:  in_inc = to_round_i[31] & in_inexact;
            RM_RUP:  in_inc = ~to_round_i[31] & in_inexact;
            RM_RMM:  in_inc = guard_i;
            default: in_rm_illegal = 1'b1;
        endcase
    end

    // Stage 1 registers
    logic [31:0] s1_data;
    logic [2:0]  s1_rm;
    logic        s1_inc;
    logic        s1_inexact;
    logic        s1_rm_illegal;
    logic        s1_of;
    logic        s1_uf;
    logic        s1_nv;
    logic        s1_dz;

    // ---------------------------------------------------------------
    // Stage 2 datapath: apply increment, saturate, exception overrides
    // ---------------------------------------------------------------
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [22:0] s1_mant;
    logic [30:0] mag_rnd;
    logic        rnd_ovf;
    logic        is_special;
    logic        sat_to_inf;
    logic [31:0] s2_result_d;
    logic [4:0]  s2_fflags_d;

    assign s1_sign = s1_data[31];
    assign s1_exp  = s1_data[30:23];
    assign s1_mant = s1_data[22:0];

    // Adding to the 31-bit magnitude lets a mantissa carry ripple into the
    // exponent, which is exactly the renormalisation a 1.111..1 + ulp needs.
    assign mag_rnd    = s1_data[30:0] + {30'd0, s1_inc};
    assign rnd_ovf    = (s1_exp != 8'hFF) && (mag_rnd[30:23] == 8'hFF);
    assign is_special = (s1_exp == 8'hFF) && !s1_of;

    // Directed modes saturate to infinity only when rounding away from zero.
    always_comb begin
        sat_to_inf = 1'b1;
        case (s1_rm)
            RM_RNE:  sat_to_inf = 1'b1;
            RM_RTZ:  sat_to_inf = 1'b0;
            RM_RDN:  sat_to_inf = s1_sign;
            RM_RUP:  sat_to_inf = ~s1_sign;
            RM_RMM:  sat_to_inf = 1'b1;
            default: sat_to_inf = 1'b1;
        endcase
    end

    always_comb begin
        s2_result_d = {s1_sign, mag_rnd};
        s2_fflags_d = {3'b000, s1_uf & s1_inexact, s1_inexact};
        if (s1_rm_illegal) begin
            s2_result_d = CANON_NAN;
            s2_fflags_d = 5'b10000;
        end else if (s1_nv) begin
            s2_result_d = CANON_NAN;
            s2_fflags_d = 5'b10000;
        end else if (s1_dz) begin
            s2_result_d = s1_data;
            s2_fflags_d = 5'b01000;
        end else if (s1_of || rnd_ovf) begin
            s2_result_d = {s1_sign, sat_to_inf ? INF_MAG : MAX_MAG};
            s2_fflags_d = {2'b00, 1'b1, s1_uf & s1_inexact, 1'b1};
        end else if (is_special) begin
            s2_result_d = (s1_mant != 23'd0) ? CANON_NAN : s1_data;
            s2_fflags_d = 5'b00000;
        end
    end

    // ---------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values and the two stages shift together.
    // NOTE: data registers are reset along with the valid bits because the
    // reset values of result_o and fflags_o are observable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            s1_rm         <= '0;
            s1_inc        <= 1'b0;
            s1_inexact    <= 1'b0;
            s1_rm_illegal <= 1'b0;
            s1_of         <= 1'b0;
            s1_uf         <= 1'b0;
            s1_nv         <= 1'b0;
            s1_dz         <= 1'b0;
            s2_valid      <= 1'b0;
            result_o      <= '0;
            fflags_o      <= '0;
        end else if (clk_en_i) begin
            if (s1_adv) begin
                s1_valid <= valid_i;
                if (valid_i) begin
                    s1_data       <= to_round_i;
                    s1_rm         <= rm_i;
                    s1_inc        <= in_inc;
                    s1_inexact    <= in_inexact;
                    s1_rm_illegal <= in_rm_illegal;
                    s1_of         <= overflow_i;
                    s1_uf         <= underflow_i;
                    s1_nv         <= invalid_op_i;
                    s1_dz         <= zero_divide_i;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    result_o <= s2_result_d;
                    fflags_o <= s2_fflags_d;
                end
            end
        end
    end

endmodule
